bus_interface_axil_regs: RTL and testbench



---
 rtl/bus_interface_pkg.sv | 33 +++
 rtl/bus_interface_axil_regs.sv | 176 +++++++++++++++++
 tb/tb_bus_interface_axil_regs.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_interface_pkg.sv
// rtl/bus_interface_pkg.sv - shared constants, FSM states and strobe merge for the AXI4-Lite register file
package bus_interface_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         ADDR_LSB  = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] apply_wstrb(
    input logic [31:0] old_word,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bus_interface_axil_regs.sv
// rtl/bus_interface_axil_regs.sv - AXI4-Lite slave with four byte-strobed read/write registers
module bus_interface_axil_regs
  import bus_interface_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                           ACLK,
  input  logic                                           ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic [2:0]                                     S_AXI_AWPROT,
  input  logic                                           S_AXI_AWVALID,
  output logic                                           S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
  input  logic                                           S_AXI_WVALID,
  output logic                                           S_AXI_WREADY,
  output logic [1:0]                                     S_AXI_BRESP,
  output logic                                           S_AXI_BVALID,
  input  logic                                           S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic [2:0]                                     S_AXI_ARPROT,
  input  logic                                           S_AXI_ARVALID,
  output logic                                           S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                                     S_AXI_RRESP,
  output logic                                           S_AXI_RVALID,
  input  logic                                           S_AXI_RREADY,
  output logic [(32 << (C_S_AXI_ADDR_WIDTH-ADDR_LSB))-1:0] reg_q,
  output logic [(1 << (C_S_AXI_ADDR_WIDTH-ADDR_LSB))-1:0]  reg_wr_pulse
);

  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int NUM_REGS = 1 << IDX_W;

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                commit;
  logic [IDX_W-1:0]    commit_idx;
  logic [31:0]         commit_data;
  logic [3:0]          commit_strb;

  logic [IDX_W-1:0]    aw_addr_idx;
  logic [IDX_W-1:0]    ar_addr_idx;
  logic                unused_inputs;

  assign aw_addr_idx   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_addr_idx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write channel FSM: accept AW and W in either order, commit when both are present.
  always_comb begin
    w_state_d   = w_state_q;
    aw_idx_d    = aw_idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    commit      = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          commit      = 1'b1;
          commit_idx  = aw_addr_idx;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
          w_state_d   = W_RESP;
        end else if (S_AXI_AWVALID) begin
          aw_idx_d  = aw_addr_idx;
          w_state_d = W_HAVE_ADDR;
        end else if (S_AXI_WVALID) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (S_AXI_WVALID) begin
          commit      = 1'b1;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
          w_state_d   = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        if (S_AXI_AWVALID) begin
          commit     = 1'b1;
          commit_idx = aw_addr_idx;
          w_state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Register array update and the per-register write pulse (fires even with an all-zero strobe).
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (commit) begin
      regs_d[commit_idx]     = apply_wstrb(regs_q[commit_idx], commit_data, commit_strb);
      wr_pulse_d[commit_idx] = 1'b1;
    end
  end

  // Read channel FSM: capture from the pre-write register value on the AR handshake.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          rdata_d   = regs_q[ar_addr_idx];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and storage flops; reset aborts any transaction in flight.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Flatten the register array for user logic.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[32*i +: 32] = regs_q[i];
  end

  assign S_AXI_AWREADY = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA);
  assign S_AXI_WREADY  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = (r_state_q == R_IDLE);
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_bus_interface_axil_regs.sv
// tb/tb_bus_interface_axil_regs.sv - self-checking bench for the AXI4-Lite register file
module tb_bus_interface_axil_regs;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b1;
  logic [3:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b0;
  logic [3:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b0;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  int tests = 0;
  int fails = 0;

  bus_interface_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  // Transaction-level reference: pending address/data flags instead of a state machine.
  logic [31:0] m_regs [4] = '{default: 32'h0};
  logic        m_have_aw = 1'b0;
  logic [1:0]  m_aw_idx = '0;
  logic        m_have_w = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic        m_bvalid = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [3:0]  m_pulse = '0;

  function automatic logic [1:0] m_wr_idx();
    return m_have_aw ? m_aw_idx : S_AXI_AWADDR[3:2];
  endfunction

  function automatic logic [31:0] m_merged();
    logic [31:0] d, mask;
    logic [3:0]  s;
    d    = m_have_w ? m_wdata : S_AXI_WDATA;
    s    = m_have_w ? m_wstrb : S_AXI_WSTRB;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (m_regs[m_wr_idx()] & ~mask) | (d & mask);
  endfunction

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= '0;
      m_have_aw <= 1'b0; m_have_w <= 1'b0; m_aw_idx <= '0;
      m_wdata <= '0; m_wstrb <= '0;
      m_bvalid <= 1'b0; m_rvalid <= 1'b0; m_rdata <= '0; m_pulse <= '0;
    end else begin
      if (!m_rvalid && S_AXI_ARVALID) begin
        m_rvalid <= 1'b1;
        m_rdata  <= m_regs[S_AXI_ARADDR[3:2]];
      end else if (m_rvalid && S_AXI_RREADY) begin
        m_rvalid <= 1'b0;
      end
      m_pulse <= '0;
      if (m_bvalid) begin
        if (S_AXI_BREADY) m_bvalid <= 1'b0;
      end else if ((m_have_aw || S_AXI_AWVALID) && (m_have_w || S_AXI_WVALID)) begin
        m_regs[m_wr_idx()] <= m_merged();
        m_pulse   <= 4'b0001 << m_wr_idx();
        m_bvalid  <= 1'b1;
        m_have_aw <= 1'b0;
        m_have_w  <= 1'b0;
      end else begin
        if (S_AXI_AWVALID && !m_have_aw) begin
          m_have_aw <= 1'b1;
          m_aw_idx  <= S_AXI_AWADDR[3:2];
        end
        if (S_AXI_WVALID && !m_have_w) begin
          m_have_w <= 1'b1;
          m_wdata  <= S_AXI_WDATA;
          m_wstrb  <= S_AXI_WSTRB;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the reference.
  always @(negedge ACLK) begin
    logic [172:0] exp_v, act_v;
    exp_v = {!m_bvalid && !m_have_aw, !m_bvalid && !m_have_w, !m_rvalid, m_bvalid, m_rvalid,
             2'b00, 2'b00, m_pulse, m_rdata, m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    act_v = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
             S_AXI_BRESP, S_AXI_RRESP, reg_wr_pulse, S_AXI_RDATA, reg_q};
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL cycle_check t=%0t got %h expected %h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic finish_b();
    int c = 0;
    S_AXI_BREADY = 1'b1;
    while (!S_AXI_BVALID && c < 40) begin tick(); c++; end
    chk("b_wait", {31'b0, S_AXI_BVALID}, 32'd1);
    chk("bresp", {30'b0, S_AXI_BRESP}, 32'd0);
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input bit wait_b);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && c < 40) begin
      S_AXI_AWVALID = !aw_done && (c >= aw_dly);
      S_AXI_WVALID  = !w_done && (c >= w_dly);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      c++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("write_handshakes", {30'b0, aw_done, w_done}, 32'd3);
    chk("bvalid_after_commit", {31'b0, S_AXI_BVALID}, 32'd1);
    chk("wr_pulse", {28'b0, reg_wr_pulse}, 32'd1 << addr[3:2]);
    if (wait_b) finish_b();
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [31:0] data);
    int c = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && c < 40) begin tick(); c++; end
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("rvalid_after_ar", {31'b0, S_AXI_RVALID}, 32'd1);
    chk("rresp", {30'b0, S_AXI_RRESP}, 32'd0);
    data = S_AXI_RDATA;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] vals [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    bit aw_hs, w_hs, ar_hs;

    #1 ARESETN = 1'b0;
    repeat (3) tick();
    ARESETN = 1'b1;
    chk("rst_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
    chk("rst_wready", {31'b0, S_AXI_WREADY}, 32'd1);
    chk("rst_arready", {31'b0, S_AXI_ARREADY}, 32'd1);
    chk("rst_valids", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_regs_zero", {31'b0, |reg_q}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), vals[i], 4'hF, 0, 0, 1);
      do_read(4'(i * 4), rd);
      chk("seq_readback", rd, vals[i]);
    end

    do_write(4'h4, 32'h55aa1234, 4'hF, 0, 2, 1);
    do_write(4'h4, 32'h0f0f0f0f, 4'hF, 2, 0, 1);
    do_read(4'h4, rd);
    chk("w_before_aw", rd, 32'h0f0f0f0f);

    do_write(4'h4, 32'habcd0001, 4'hF, 0, 0, 1);
    do_write(4'h4, 32'h11223344, 4'b0101, 0, 0, 0);
    tick();
    chk("pulse_one_cycle", {28'b0, reg_wr_pulse}, 32'd0);
    finish_b();
    do_read(4'h4, rd);
    chk("strobe_merge", rd, 32'hab220044);
    chk("model_strobe_merge", m_regs[1], 32'hab220044);

    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h600dcafe; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'hbad0bad0; S_AXI_ARADDR = 4'h4;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valids", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'd3);
      chk("bp_readies", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
      chk("bp_rdata", S_AXI_RDATA, 32'h0101FFFF);
      tick();
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    chk("bp_no_second_write", reg_q[95:64], 32'hdead0011);
    chk("bp_write_landed", reg_q[127:96], 32'h600dcafe);

    do_write(4'h8, 32'hdead0011, 4'hF, 0, 0, 1);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("same_edge_old_value", S_AXI_RDATA, 32'hdead0011);
    finish_b();
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    do_read(4'h8, rd);
    chk("same_edge_new_value", rd, 32'h12345678);

    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hcafef00d; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("pre_reset_valids", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'd3);
    #2 ARESETN = 1'b0;
    #1;
    chk("reset_drops_valids", {30'b0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    chk("reset_clears_regs", {31'b0, |reg_q}, 32'd0);
    tick();
    ARESETN = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), rd);
      chk("post_reset_read", rd, 32'd0);
    end

    for (int cyc = 0; cyc < 1500; cyc++) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      if (aw_hs || !S_AXI_AWVALID) begin
        S_AXI_AWVALID = ($urandom_range(0, 2) == 0);
        S_AXI_AWADDR  = 4'($urandom);
      end
      if (w_hs || !S_AXI_WVALID) begin
        S_AXI_WVALID = ($urandom_range(0, 2) == 0);
        S_AXI_WDATA  = $urandom;
        S_AXI_WSTRB  = 4'($urandom);
      end
      if (ar_hs || !S_AXI_ARVALID) begin
        S_AXI_ARVALID = ($urandom_range(0, 2) == 0);
        S_AXI_ARADDR  = 4'($urandom);
      end
      S_AXI_BREADY = 1'($urandom_range(0, 1));
      S_AXI_RREADY = 1'($urandom_range(0, 1));
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
